// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, enable levels and types for the fetch stage
package inst_fetch_pkg;
  localparam int InstAddrWidth = 32;
  localparam int InstDataWidth = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic ChipEnable = 1'b1;
  localparam logic [InstDataWidth-1:0] ZeroWord = '0;
  typedef logic [InstAddrWidth-1:0] addr_t;
  typedef logic [InstDataWidth-1:0] data_t;
endpackage

// File: rtl/inst_fetch_if_id.sv
// inst_fetch_if_id: IF/ID pipeline register with stall, flush and bubble handling
module inst_fetch_if_id
  import inst_fetch_pkg::*;
#(
  parameter bit DelaySlot = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  input  logic  branch_flag,
  input  addr_t pc,
  input  data_t inst,
  input  logic  ce,
  output addr_t id_pc,
  output data_t id_inst,
  output logic  id_valid,
  output logic  id_adel
);
  logic mis;
  logic bubble;
  assign mis = pc[1:0] != 2'b00;
  assign bubble = rst == RstEnable || flush || (!stall && branch_flag && !DelaySlot);
  // flush beats stall; a squashed delay slot loads the same NOP as reset
  always_ff @(posedge clk) begin
    if (bubble) begin
      id_pc <= '0;
      id_inst <= ZeroWord;
      id_valid <= 1'b0;
      id_adel <= 1'b0;
    end else if (!stall) begin
      id_pc <= pc;
      id_inst <= mis ? ZeroWord : inst;
      id_valid <= ce == ChipEnable;
      id_adel <= ce == ChipEnable && mis;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: program counter, ROM enable and next-PC selection feeding IF/ID
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter addr_t ResetPC = 32'h0000_0000,
  parameter bit DelaySlot = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  input  addr_t flush_pc,
  input  logic  branch_flag,
  input  addr_t branch_target,
  output logic  rom_ce,
  output addr_t rom_addr,
  input  data_t rom_inst,
  output addr_t id_pc,
  output data_t id_inst,
  output logic  id_valid,
  output logic  id_adel
);
  addr_t pc;
  addr_t next_pc;
  assign rom_addr = pc;
  // stall holds PC and ignores branch_flag since ID re-asserts the held branch
  always_comb next_pc = flush ? flush_pc : stall ? pc : branch_flag ? branch_target : pc + 32'd4;
  // first enabled cycle after reset fetches ResetPC before sequencing begins
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc <= ResetPC;
      rom_ce <= ~ChipEnable;
    end else if (rom_ce != ChipEnable) begin
      pc <= ResetPC;
      rom_ce <= ChipEnable;
    end else begin
      pc <= next_pc;
    end
  end
  inst_fetch_if_id #(.DelaySlot(DelaySlot)) u_if_id (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .branch_flag(branch_flag),
    .pc(pc),
    .inst(rom_inst),
    .ce(rom_ce),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_valid(id_valid),
    .id_adel(id_adel)
  );
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the instruction ROM: owns the program counter, drives the ROM's `ce`/`addr` pair, and registers the returned instruction with its PC into the IF/ID pipeline register. It sits between the combinational instruction ROM and the decode stage. It accepts sequential advance, taken-branch redirect, pipeline stall and exception flush from the rest of the CPU.

## Interface
Parameters:
- `ResetPC`, 32'h0000_0000: first fetch address after reset.
- `DelaySlot`, 1: 1 = MIPS branch delay slot, so the instruction fetched alongside a taken branch proceeds; 0 = that instruction is squashed.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset; compared against `` `RstEnable ``.
- `stall`  in  1  hold PC and IF/ID register.
- `flush`  in  1  exception/eret redirect; highest priority after `rst`.
- `flush_pc`  in  `` `InstAddrWidth ``  target address for `flush`.
- `branch_flag`  in  1  taken branch/jump resolved in ID.
- `branch_target`  in  `` `InstAddrWidth ``  target address for `branch_flag`.
- `rom_ce`  out  1  ROM chip enable (`` `ChipEnable `` / `` ~`ChipEnable ``).
- `rom_addr`  out  `` `InstAddrWidth ``  byte address equal to the current PC.
- `rom_inst`  in  `` `InstDataWidth ``  combinational ROM data, returns 0 when `ce` is disabled.
- `id_pc`  out  `` `InstAddrWidth ``  PC of the registered instruction.
- `id_inst`  out  `` `InstDataWidth ``  registered instruction (0 = NOP).
- `id_valid`  out  1  `id_inst` is a real fetched instruction.
- `id_adel`  out  1  fetch address misaligned (`pc[1:0]!=0`); travels with the instruction.

## Operation
- PC register `pc` drives `rom_addr` directly. `rom_ce` is a registered enable.
- Next-PC priority, evaluated each edge: `rst` > `flush` > `stall` > `branch_flag` > sequential.
  - `rst`: `pc<=ResetPC`, `rom_ce<=~ChipEnable`.
  - `rom_ce` disabled and not reset: `rom_ce<=ChipEnable`; `pc` stays at `ResetPC`.
  - `flush`: `pc<=flush_pc`.
  - `stall`: `pc` holds. `branch_flag` is ignored, because ID holds the branch and re-asserts it.
  - `branch_flag`: `pc<=branch_target`.
  - Otherwise: `pc<=pc+4`, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- IF/ID register, same priority:
  - `rst` or `flush`: `id_pc<=0`, `id_inst<=0`, `id_valid<=0`, `id_adel<=0`.
  - `stall`: all IF/ID outputs hold.
  - `branch_flag` with `DelaySlot==0`: load the NOP bubble (same values as reset).
  - Otherwise: `id_pc<=pc`, `id_inst<=rom_inst`, `id_valid<=rom_ce`, `id_adel<=rom_ce&(pc[1:0]!=0)`.
- Misaligned PC (only reachable through `branch_target`/`flush_pc`):
  - The ROM is still addressed; `id_inst` is forced to 0 and `id_adel` is set.
  - The PC continues sequentially from the misaligned value until ID/exception logic flushes.

## Timing
- Reset values: `pc=ResetPC`, `rom_ce=~ChipEnable`, `id_pc=0`, `id_inst=0`, `id_valid=0`, `id_adel=0`.
- Reset release (first edge with `rst` low):
  - Cycle 0: `rom_ce` rises, `rom_addr=ResetPC`.
  - Cycle 1: `id_inst=ROM[ResetPC]`, `id_valid=1`.
- Fetch latency: 1 cycle from `rom_addr` to `id_inst`; throughput 1 instruction/cycle.
- Redirect: a `branch_flag` sampled at edge N puts `branch_target` on `rom_addr` after N; its instruction reaches ID after N+1.
- `rst` mid-run: takes effect at the next edge regardless of `stall`/`flush`; the following cycle repeats the reset-release sequence.
- `flush` and `stall` together: flush wins, and the IF/ID register loads the bubble.
- Deasserting `stall` resumes from the held PC. No instruction is lost or duplicated.

## Structure
- `` `InstAddrWidth ``, `` `InstDataWidth ``, `` `RstEnable ``, `` `ChipEnable ``, and a new `` `ZeroWord `` (NOP) all live in the shared `define.v`.
- One natural sub-module, `if_id`: the IF/ID pipeline register, with its stall/flush/bubble logic.
- The top level holds the PC, next-PC mux and `rom_ce` register.

## Test plan
- Reset release with the ROM preloaded with 32 distinct words -> `rom_addr` steps 0,4,8,… each cycle; `id_inst` equals `ROM[i]` one cycle later; `id_valid=1` from the second cycle.
- `branch_flag=1`, `branch_target=32'h40` at PC 0x10, `DelaySlot=1`:
  - Required: ID sees 0x10, then 0x40.
  - Same stimulus with `DelaySlot=0`: ID sees a bubble (`id_valid=0`), then 0x40.
- `stall` held 3 cycles at PC 0x20 -> `rom_addr` stays 0x20 and `id_*` frozen for 3 cycles; after release, 0x24 is the next new PC and no instruction is repeated.
- `flush=1`, `flush_pc=32'h180`, asserted together with `stall` and `branch_flag` -> next `rom_addr=0x180`, `id_valid=0`.
- `branch_target=32'h42` -> `id_adel=1`, `id_inst=0`. `pc=32'hFFFF_FFFC` advancing -> next `pc=0`.
- `rst` asserted mid-run, during a stall -> all outputs at reset values one edge later; fetch restarts at `ResetPC`.
